// File: rtl/fifo_n2w_pkg.sv
// Shared constants and helpers for the nibble-to-byte width-converting FIFO.
// The packing helper fixes the byte layout in one place: the older nibble
// always ends up in the upper half of the returned byte.
package fifo_n2w_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    // Build a byte from two nibbles, the first-written one in the upper half.
    function automatic logic [BYTE_W-1:0] n2w_pack(input logic [NIBBLE_W-1:0] hi,
                                                   input logic [NIBBLE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/register_file_2_read_port.sv
// Small register file with one synchronous write port and two asynchronous
// read ports. The FIFO uses the two read ports to see the oldest nibble and
// its partner at the same time. Contents are deliberately not reset.
module register_file_2_read_port
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
)
(
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_2,
    output logic [DATA_WIDTH-1:0] o_data_1,
    output logic [DATA_WIDTH-1:0] o_data_2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store one word per accepted write; no reset so this maps onto plain RAM/flops.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_data_1 = r_mem[i_addr_1];
    assign o_data_2 = r_mem[i_addr_2];

endmodule

// File: rtl/fifo_narrow_to_wide.sv
// Width-converting FIFO: one nibble in per write, one byte out per read.
// The byte shown on read_data_o is the two oldest nibbles, first-written in
// the upper half, and is visible combinationally whenever empty_o is low.
// Optional feature macro: FIFO_N2W_LEVEL_EN adds the level_o port, which
// reports the registered nibble count.
module fifo_narrow_to_wide
    import fifo_n2w_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = NIBBLE_W
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    write_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic                    read_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [2*DATA_WIDTH-1:0] read_data_o
`ifdef FIFO_N2W_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]     level_o
`endif
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_TWO = ADDR_WIDTH'(2);

    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH-1:0]   r_rptr;
    logic [CW-1:0]           r_count;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_wrOk;
    logic                    w_rdOk;
    logic [ADDR_WIDTH-1:0]   w_rptrPartner;
    logic [DATA_WIDTH-1:0]   w_hiNibble;
    logic [DATA_WIDTH-1:0]   w_loNibble;
    logic [2*DATA_WIDTH-1:0] w_byte;

    // Flags come only from the registered count, so a write is never readable
    // in the cycle it lands and a full-cycle write is dropped even if a read
    // frees space on the same edge.
    assign w_empty = (r_count < CNT_TWO);
    assign w_full  = (r_count == CNT_FULL);
    assign w_wrOk  = write_i & ~w_full;
    assign w_rdOk  = read_i & ~w_empty;

    // rptr stays even and DEPTH is even, so the partner address never wraps on its own.
    assign w_rptrPartner = r_rptr + PTR_ONE;

    register_file_2_read_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regFile (
        .i_clk    (clk_i),
        .i_we     (w_wrOk),
        .i_waddr  (r_wptr),
        .i_wdata  (write_data_i),
        .i_addr_1 (r_rptr),
        .i_addr_2 (w_rptrPartner),
        .o_data_1 (w_hiNibble),
        .o_data_2 (w_loNibble)
    );

    generate
        if (DATA_WIDTH == NIBBLE_W) begin : g_packNibble
            assign w_byte = n2w_pack(w_hiNibble, w_loNibble);
        end else begin : g_packGeneric
            assign w_byte = {w_hiNibble, w_loNibble};
        end
    endgenerate

    // Pointers and count advance on accepted transfers; a read retires two nibbles at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wrOk) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rdOk) begin
                r_rptr <= r_rptr + PTR_TWO;
            end
            r_count <= r_count + (w_wrOk ? CNT_ONE : CNT_ZERO)
                               - (w_rdOk ? CNT_TWO : CNT_ZERO);
        end
    end

    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign read_data_o = w_empty ? '0 : w_byte;

`ifdef FIFO_N2W_LEVEL_EN
    assign level_o = r_count;
`endif

endmodule
